// File: rtl/cfg_chain_loader.sv
// Config chain loader: accepts host words over valid/ready and shifts them onto
// CHAINS parallel fabric config chains, holding config_en for exactly CHAIN_LEN shifts.
module cfg_chain_loader #(
   parameter int CHAINS    = 2,
   parameter int CHAIN_LEN = 35,
   parameter int WORD_W    = 8
) (
   input  logic              clk,
   input  logic              nrst,
   input  logic              start,
   input  logic              abort,
   input  logic [WORD_W-1:0] wdata,
   input  logic              wvalid,
   output logic              wready,
   output logic              cfg_en,
   output logic              cfg_shift,
   output logic [CHAINS-1:0] cfg_data,
   output logic              busy,
   output logic              done,
   output logic              aborted
);

   localparam int WPS = WORD_W / CHAINS;
   localparam int CW  = $clog2(CHAIN_LEN + 1);
   localparam int RW  = $clog2(WPS + 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_LOAD  = 2'd1;
   localparam logic [1:0] S_SHIFT = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   localparam logic [CW-1:0] LAST  = CW'(CHAIN_LEN);
   localparam logic [RW-1:0] WPS_R = RW'(WPS);

   logic [1:0]        state, state_n;
   logic [CW-1:0]     count, count_n, left;
   logic [RW-1:0]     rem, rem_n;
   logic [WORD_W-1:0] sbuf, sbuf_n;
   logic [CHAINS-1:0] data_n;
   logic              abort_n;

   // rem counts the shifts still owed by the current word, including the one
   // being presented; all outputs are registered from the next-state values.
   always_comb begin
      state_n = state;
      count_n = count;
      rem_n   = rem;
      sbuf_n  = sbuf;
      data_n  = '0;
      abort_n = 1'b0;
      left    = LAST - count;
      case (state)
         S_IDLE: begin
            if (start && !abort) begin
               state_n = S_LOAD;
               count_n = '0;
            end
         end
         S_LOAD: begin
            if (abort) begin
               state_n = S_IDLE;
               abort_n = 1'b1;
            end else if (wvalid && wready) begin
               state_n = S_SHIFT;
               data_n  = wdata[CHAINS-1:0];
               sbuf_n  = wdata >> CHAINS;
               rem_n   = (int'(left) < WPS) ? RW'(left) : WPS_R;
            end
         end
         S_SHIFT: begin
            if (abort) begin
               state_n = S_IDLE;
               abort_n = 1'b1;
            end else begin
               count_n = count + CW'(1);
               if (rem == RW'(1)) begin
                  state_n = (count_n == LAST) ? S_DONE : S_LOAD;
               end else begin
                  data_n = sbuf[CHAINS-1:0];
                  sbuf_n = sbuf >> CHAINS;
                  rem_n  = rem - RW'(1);
               end
            end
         end
         S_DONE:  state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state     <= S_IDLE;
         count     <= '0;
         rem       <= '0;
         sbuf      <= '0;
         wready    <= 1'b0;
         cfg_en    <= 1'b0;
         cfg_shift <= 1'b0;
         cfg_data  <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         aborted   <= 1'b0;
      end else begin
         state     <= state_n;
         count     <= count_n;
         rem       <= rem_n;
         sbuf      <= sbuf_n;
         wready    <= (state_n == S_LOAD);
         cfg_en    <= (state_n == S_LOAD) || (state_n == S_SHIFT);
         cfg_shift <= (state_n == S_SHIFT);
         cfg_data  <= data_n;
         busy      <= (state_n == S_LOAD) || (state_n == S_SHIFT);
         done      <= (state_n == S_DONE);
         aborted   <= abort_n;
      end
   end

endmodule

// File: doc/cfg_chain_loader.md
# cfg_chain_loader

Bitstream loader that sequences configuration of a fabric tile's parallel config shift chains, such as the dual-bank A/B chains of a connection box. It accepts configuration words from a host over a valid/ready stream. It serializes each word onto CHAINS parallel serial outputs and generates the tile's `config_en` and shift-enable. It releases the fabric after exactly CHAIN_LEN shifts. The block sits between the host/bitstream port and the first tile of each daisy-chained config path.

## Interface
- CHAINS, default 2: number of parallel config chains, driven in lockstep.
- CHAIN_LEN, default 35: shifts per load, the total chain length in bits per chain (7-bit select × 5 muxes).
- WORD_W, default 8: host word width; must be a multiple of CHAINS.

Ports:
- clk  input  1  clock.
- nrst  input  1  reset, asynchronous, active-low.
- start  input  1  single-cycle request to begin a load.
- abort  input  1  terminate the load in progress.
- wdata  input  WORD_W  config word; bit pair [2k+1:2k] holds shift k (chain c = bit CHAINS·k+c).
- wvalid  input  1  wdata valid.
- wready  output  1  loader accepts wdata this cycle.
- cfg_en  output  1  to fabric `config_en`; high for the whole load, tristates fabric drivers.
- cfg_shift  output  1  to fabric `en`; one chain shift per high cycle.
- cfg_data  output  CHAINS  serial data, bit c goes to chain c.
- busy  output  1  high in LOAD or SHIFT.
- done  output  1  one-cycle pulse when a load completes.
- aborted  output  1  one-cycle pulse when a load is aborted.

## Operation
- States: IDLE, LOAD, SHIFT, DONE.
- IDLE:
  - start=1 and abort=0 → LOAD; shift counter cleared to 0.
  - start while busy is ignored.
- LOAD:
  - wready=1, cfg_en=1, cfg_shift=0.
  - wvalid&&wready → capture wdata into the shift buffer and go to SHIFT.
  - Shifts allotted to the word = min(WORD_W/CHAINS, CHAIN_LEN − count).
- SHIFT, per cycle:
  - cfg_shift=1, cfg_data=buf[CHAINS-1:0], buf >>= CHAINS, count += 1.
  - After the word's allotted shifts: → LOAD if count<CHAIN_LEN, else → DONE.
  - Unused high bits of the last word are discarded.
- DONE: cfg_en=0, done=1 for one cycle, → IDLE.
- Bit ordering: the first shifted bit ends at chain MSB (chains shift left, MSB exits to the next tile). The host sends the MSB-destined select bits first.
- abort in LOAD or SHIFT:
  - Next state IDLE; cfg_en and cfg_shift drop next cycle.
  - aborted=1 for one cycle; done is not asserted.
  - Chain contents are then partial; the host must reload.
- abort in IDLE or DONE: no effect; no aborted pulse.
- start and abort in the same IDLE cycle: abort wins; stay IDLE.
- Count width: $clog2(CHAIN_LEN+1), no wrap-around; the terminal compare is ==CHAIN_LEN.
- wvalid outside LOAD is ignored; no data is consumed.

## Timing
- All outputs are registered.
- Reset values: wready=0, cfg_en=0, cfg_shift=0, cfg_data=0, busy=0, done=0, aborted=0, state IDLE, count 0.
- nrst asserted mid-load: immediate return to reset values; no done or aborted pulse.
- Start-to-first-wready latency: 1 cycle; start at cycle t → LOAD at t+1.
- A word accepted at cycle u gives cfg_shift high u+1…u+S (S = allotted shifts) and wready=0 over the same cycles. The next wready is at u+S+1.
- Default parameters: 9 words; 35 cfg_shift cycles; the last word gives 3 shifts.
- With wvalid held high, DONE is at t+1+8·5+4 = t+45; cfg_en covers t+1…t+44.
- cfg_shift is never high while cfg_en is low. cfg_en never toggles mid-load except on abort or reset.

## Test plan
- Full load, defaults, wvalid always high, words 0xE4 ×9 → cfg_data repeats 0,1,2,3 per word (last word: 0,1,2). Exactly 35 cfg_shift cycles. done at t+45, cfg_en low at t+45.
- Backpressure: wvalid low for 3 cycles before word 4 → wready stays high, cfg_shift stays low throughout the stall. Total shifts are still 35 and completion is delayed by 3 cycles.
- Abort during the 2nd shift of word 5 → aborted pulse next cycle, cfg_en=0, busy=0, no done. Count restarts at 0 on the next start.
- start and abort asserted together in IDLE → no state change, cfg_en stays 0. A start pulse mid-load → ignored, still 35 shifts.
- nrst pulsed low during SHIFT → all outputs 0 asynchronously. Then start → a normal full load completes.
- CHAIN_LEN=8, WORD_W=8, CHAINS=2 → exactly 2 words accepted, 8 shifts, then done; a 3rd wvalid is not accepted (wready=0).
